cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
Miss-handling controller between the CPU's memory-access stage (instruction or data cache) and the multi-cycle main memory.
- On a cache miss it stalls the pipeline.
- Issues one pipelined word read per cycle for the 8-word (16-byte) block.
- Streams returned words into the cache data array, then writes the tag.
- One instance per cache.

Parameters:
WORDS_PER_BLOCK, 8, words (16-bit) per cache block; power of two.
MEM_LATENCY, 4, cycles from memory_read request to matching memory_data_valid; informational, FSM counts valids, not cycles.
ADDR_W, 16, byte-address width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_W  byte address that missed
fsm_busy  output  1  fill in progress; pipeline stalls while high
memory_read  output  1  read request to main memory this cycle
memory_address  output  ADDR_W  word address of current request
memory_data  input  16  returned word
memory_data_valid  input  1  memory_data valid this cycle
write_data_array  output  1  write fill_data at fill_word this cycle
fill_word  output  log2(WORDS_PER_BLOCK)  word offset within block being written
fill_data  output  16  word to write (memory_data passthrough)
write_tag_array  output  1  one-cycle pulse: tag/valid write for block_base
block_base  output  ADDR_W  latched block-aligned address (miss_address with low 4 bits cleared)

Behaviour:
- Reset (async, any time incl. mid-fill) forces state IDLE and clears issue_cnt, recv_cnt, block_base. All outputs are 0.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall takes effect in the miss cycle).
  - On miss_detected, latch block_base = miss_address & ~0xF and go to FILL.
  - memory_data_valid in IDLE is ignored.
- FILL:
  - fsm_busy = 1.
  - Issue phase: memory_read = 1 while issue_cnt < WORDS_PER_BLOCK; memory_address = block_base + 2*word(issue_cnt); issue_cnt increments each cycle. Exactly 8 requests, one per cycle, no gaps.
  - Receive phase: each memory_data_valid asserts write_data_array, fill_word = word(recv_cnt), fill_data = memory_data, and increments recv_cnt.
  - Valid on the final word (recv_cnt == 7): write_tag_array pulses in that same cycle, counters clear, next state is IDLE.
  - Valid may overlap the issue phase.
- Default word(n) = n.
- Address arithmetic is modulo 2^ADDR_W. Block alignment means offsets never carry out of the block.
- Timing with MEM_LATENCY=4:
  - miss at cycle 0; requests in cycles 1–8; data in cycles 5–12.
  - write_tag_array in cycle 12; fsm_busy low from cycle 13.
  - Busy window 13 cycles.
- miss_detected while in FILL is ignored; the pipeline is stalled, so the address is stable.
- Extra valids beyond 8 cannot occur (IDLE after 8th); any in IDLE are ignored.
- memory_read never asserts in IDLE.

Optional Feature:
CRITICAL_WORD_FIRST_EN.
- Defined: latch start = miss_address[3:1] on miss; word(n) = (start + n) mod 8 for both requests and fill_word, so the missing word returns first.
- Undefined: start fixed at 0; word(n) = n.
- Timing identical in both builds.

Decomposition:
- Package cache_pkg: state enum (IDLE, FILL), BLOCK_BYTES=16, OFFSET_BITS=4, WORD_IDX_W=3, WORDS_PER_BLOCK.
- One sub-module: block_word_counter, a WORD_IDX_W-bit counter with async rst, clear, enable and terminal-count output.
  - Instantiated twice: issue counter and receive counter.

Test Plan:
- Reset mid-fill: assert rst at cycle 7 of a fill → all outputs 0 immediately. After release with no miss, fsm_busy stays 0 and memory_read stays 0.
- Basic miss: miss_address=0x1236 at cycle 0, memory model latency 4 → memory_address 0x1230,0x1232,…,0x123E in cycles 1–8. fill_word 0..7 in cycles 5–12 with the model's data. write_tag_array in cycle 12 only; block_base=0x1230; fsm_busy high cycles 0–12.
- Top of memory: miss_address=0xFFFF → requests 0xFFF0..0xFFFE, no wrap past 0xFFFE; tag written for block_base 0xFFF0.
- Ignored inputs: memory_data_valid pulsed in IDLE, and miss_detected held during FILL with a different address → no array writes in IDLE, block_base unchanged, exactly 8 requests.
- Back-to-back misses: second miss asserted cycle 13 → new fill starts; requests begin cycle 14; no lost or duplicated writes.
- CRITICAL_WORD_FIRST_EN build: miss_address=0x20A A (0x20AA, offset 5) → requests 0x20AA,0x20AC,0x20AE,0x20A0,…,0x20A8; fill_word sequence 5,6,7,0,1,2,3,4.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state type for the cache block-fill controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;
  localparam int OFFSET_BITS     = $clog2(BLOCK_BYTES);
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Word-index counter for one block: clear has priority over enable, wraps at 2^W.
// Latency: count updates one cycle after enable; tc is combinational from the count.
// Backpressure: none; the owner gates en.
module block_word_counter
  import cache_pkg::*;
#(
  parameter int W = WORD_IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step on enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls on a miss, issues one word read per cycle, writes words then tag.
// Latency: requests start the cycle after the miss; tag write coincides with the last returned word.
// Backpressure: memory may return valids with any spacing; no flow control toward memory requests.
// Optional build macro: CRITICAL_WORD_FIRST_EN (start the fill at the word that missed).
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_W-1:0]                  memory_address,
  input  logic [15:0]                        memory_data,
  input  logic                               memory_data_valid,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array,
  output logic [ADDR_W-1:0]                  block_base
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF   = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF;

  // Memory latency is only informational: completion is counted in valids, not cycles.
  // Unsupported configurations elaborate this marker block so they are visible in the hierarchy.
  if (MEM_LATENCY < 1 || (1 << IDX_W) != WORDS_PER_BLOCK ||
      (IDX_W == WORD_IDX_W && OFF != OFFSET_BITS) || BLOCK_BYTES < 2) begin : g_unsupported_cfg
  end

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] block_base_q, block_base_d;
  logic              issue_done_q, issue_done_d;
  logic              cnt_clr;
  logic              issue_en;
  logic              recv_en;
  logic [IDX_W-1:0]  issue_cnt, recv_cnt;
  logic [IDX_W-1:0]  issue_word, recv_word;
  logic              issue_tc, recv_tc;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]  start_q, start_d;
  // Rotate both sequences so the missing word is requested and written first.
  assign issue_word = issue_cnt + start_q;
  assign recv_word  = recv_cnt + start_q;
`else
  assign issue_word = issue_cnt;
  assign recv_word  = recv_cnt;
`endif

  block_word_counter #(.W(IDX_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  block_word_counter #(.W(IDX_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt),
    .tc  (recv_tc)
  );

  // Next-state and output decode; every output is zero unless the current state drives it.
  always_comb begin
    state_d          = state_q;
    block_base_d     = block_base_q;
    issue_done_d     = issue_done_q;
`ifdef CRITICAL_WORD_FIRST_EN
    start_d          = start_q;
`endif
    cnt_clr          = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall in the miss cycle itself; returned data here is stale and ignored.
        fsm_busy = miss_detected & ~rst;
        if (miss_detected) begin
          block_base_d = miss_address & BASE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
          start_d      = miss_address[OFF-1:1];
`endif
          state_d      = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Issue phase: one request per cycle until every word has been asked for.
        if (!issue_done_q) begin
          memory_read    = 1'b1;
          memory_address = block_base_q | {{(ADDR_W-OFF){1'b0}}, issue_word, 1'b0};
          issue_en       = 1'b1;
          if (issue_tc) begin
            issue_done_d = 1'b1;
          end
        end
        // Receive phase may overlap issue; the last word also writes the tag.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = recv_word;
          fill_data        = memory_data;
          recv_en          = 1'b1;
          if (recv_tc) begin
            write_tag_array = 1'b1;
            cnt_clr         = 1'b1;
            issue_done_d    = 1'b0;
            state_d         = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched block address and issue-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      block_base_q <= '0;
      issue_done_q <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      block_base_q <= block_base_d;
      issue_done_q <= issue_done_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q      <= start_d;
`endif
    end
  end

  assign block_base = block_base_q;

endmodule
